// File: rtl/frame_serializer.sv
// Bit-serial transmitter for interleaved codeword frames.
// Each accepted frame goes out as preamble, then payload MSB first, then one
// even-parity bit, with no gaps. All outputs are registered.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a frame; in_ready high, line quiet
// S_PREAMBLE | sending preamble bits PREAMBLE[PRE_LEN-1] .. PREAMBLE[0]
// S_DATA     | sending payload bits from the shift register MSB
// S_PARITY   | sending the even-parity bit; tx_eof high
module frame_serializer #(
    parameter int          WIDTH    = 44,
    parameter int          PRE_LEN  = 8,
    parameter logic [15:0] PREAMBLE = 16'h00A5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_bit,
    output logic             tx_en,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             busy
);

    localparam int MAXL = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_PARITY   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             par, par_nxt;

    logic             ready_q, busy_q;
    logic             tx_bit_q, tx_en_q, tx_sof_q, tx_eof_q;
    logic             ready_d, busy_d;
    logic             tx_bit_d, tx_en_d, tx_sof_d, tx_eof_d;

    logic             accept;
    logic [15:0]      pre_sh;

    // in_ready is a register so it reads 0 during reset and rises one edge after release
    assign accept   = in_valid && ready_q;
    assign pre_sh   = PREAMBLE >> cnt_nxt;

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign tx_bit   = tx_bit_q;
    assign tx_en    = tx_en_q;
    assign tx_sof   = tx_sof_q;
    assign tx_eof   = tx_eof_q;

    // State, datapath and registered outputs; async reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sreg     <= '0;
            par      <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            tx_bit_q <= 1'b0;
            tx_en_q  <= 1'b0;
            tx_sof_q <= 1'b0;
            tx_eof_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sreg     <= sreg_nxt;
            par      <= par_nxt;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            tx_bit_q <= tx_bit_d;
            tx_en_q  <= tx_en_d;
            tx_sof_q <= tx_sof_d;
            tx_eof_q <= tx_eof_d;
        end
    end

    // Next state: down-counter holds the index of the bit being sent, reloaded on every state change
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        par_nxt   = par;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_PREAMBLE;
                    cnt_nxt   = CW'(PRE_LEN - 1);
                    sreg_nxt  = in_data;
                    par_nxt   = ^in_data;
                end
            end
            S_PREAMBLE: begin
                if (cnt == '0) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = CW'(WIDTH - 1);
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            S_DATA: begin
                // the MSB on the line this cycle is consumed, expose the next one
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                if (cnt == '0) begin
                    state_nxt = S_PARITY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            S_PARITY: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        tx_bit_d = 1'b0;
        tx_en_d  = (state_nxt != S_IDLE);
        tx_sof_d = 1'b0;
        tx_eof_d = 1'b0;
        busy_d   = (state_nxt != S_IDLE);
        ready_d  = (state_nxt == S_IDLE);
        case (state_nxt)
            S_PREAMBLE: begin
                tx_bit_d = pre_sh[0];
                tx_sof_d = (state == S_IDLE);
            end
            S_DATA: begin
                tx_bit_d = sreg_nxt[WIDTH-1];
            end
            S_PARITY: begin
                tx_bit_d = par_nxt;
                tx_eof_d = 1'b1;
            end
            default: begin
                tx_bit_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Testbench for frame_serializer: directed steps plus random frames, with a
// serial receiver model checking every frame against a scoreboard queue.
module tb_frame_serializer;

    logic        clk;
    logic        rst_n;
    logic [43:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx_bit;
    logic        tx_en;
    logic        tx_sof;
    logic        tx_eof;
    logic        busy;

    int          checks    = 0;
    int          failures  = 0;
    int          frames_tx = 0;
    int          frames_rx = 0;
    int          aborted   = 0;

    logic [43:0] sb[$];

    bit          in_frame  = 0;
    int          nbits     = 0;
    logic [52:0] rx        = '0;
    logic [43:0] exp_d;

    frame_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .tx_en    (tx_en),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a frame and wait (bounded) for the handshake; the scoreboard gets
    // in_data exactly as it stands at the accepting edge. With churn set,
    // in_data changes every waiting cycle and in_valid stays high afterwards.
    task automatic send(input logic [43:0] d, input int gap, input bit churn, output time t_acc);
        logic [63:0] r;
        int          to;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        to = 0;
        while (!in_ready && to < 200) begin
            @(negedge clk);
            if (churn) begin
                r = {$urandom, $urandom};
                in_data = r[43:0];
            end
            to++;
        end
        chk("accept_timeout", (to < 200), 1);
        sb.push_back(in_data);
        frames_tx++;
        @(posedge clk);
        t_acc = $time;
        #1;
        r = {$urandom, $urandom};
        in_data = r[43:0];
        if (!churn) in_valid = 1'b0;
    endtask

    // Serial receiver model: rebuilds each frame and checks it against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_frame && sb.size() > 0) begin
                void'(sb.pop_front());
                aborted++;
            end
            in_frame = 0;
        end else begin
            chk("busy_vs_en", busy, tx_en);
            if (!tx_en) begin
                chk("idle_bit", tx_bit, 0);
                if (in_frame) begin
                    chk("en_gap", tx_en, 1);
                    in_frame = 0;
                end
            end else begin
                if (!in_frame) begin
                    chk("sof_first", tx_sof, 1);
                    in_frame = 1;
                    nbits    = 0;
                    rx       = '0;
                end else begin
                    chk("sof_extra", tx_sof, 0);
                end
                rx = {rx[51:0], tx_bit};
                nbits++;
                if (tx_eof) begin
                    chk("frame_len", nbits, 53);
                    chk("preamble", rx[52:45], 8'hA5);
                    if (sb.size() > 0) begin
                        exp_d = sb.pop_front();
                        chk("data", rx[44:1], exp_d);
                        chk("parity", rx[0], ^exp_d);
                    end else begin
                        chk("sb_underflow", sb.size(), 1);
                    end
                    in_frame = 0;
                    frames_rx++;
                end else if (nbits >= 53) begin
                    chk("eof_missing", tx_eof, 1);
                end
            end
        end
    end

    initial begin
        time t1, t2, tdummy;
        int  n, to;
        logic [63:0] r;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // 1. reset state, then in_ready one cycle after release
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_sof", tx_sof, 0);
        chk("rst_tx_eof", tx_eof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_tx_en", tx_en, 0);

        // 2. all-zero payload: sof with first preamble bit, 53 enabled cycles
        send(44'h0, 0, 0, t1);
        @(negedge clk);
        chk("sof_k1", tx_sof, 1);
        chk("first_bit", tx_bit, 1);
        n = 1;
        repeat (60) begin
            @(negedge clk);
            if (tx_en) n++;
        end
        chk("en_cycles", n, 53);

        // 3. payload boundary bits and parity
        send(44'h000_0000_0001, 0, 0, tdummy);
        send(44'h800_0000_0001, 0, 0, tdummy);

        // 4. in_valid held with changing data: second accept exactly 54 cycles later
        send(44'h123_4567_89AB, 0, 1, t1);
        @(negedge clk);
        chk("ready_low_in_frame", in_ready, 0);
        send(44'hFED_CBA9_8765, 0, 1, t2);
        chk("accept_spacing", (t2 - t1), 540);
        in_valid = 1'b0;

        // 5. asynchronous reset during data bit 20
        r = {$urandom, $urandom};
        send(r[43:0], 0, 0, t1);
        repeat (29) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_en", tx_en, 0);
        chk("arst_tx_bit", tx_bit, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", in_ready, 1);
        chk("arst_rel_en", tx_en, 0);
        send(44'hA5A_5A5A_5A5A, 0, 0, tdummy);

        // 6. random frames with random idle gaps
        for (int i = 0; i < 200; i++) begin
            r = {$urandom, $urandom};
            send(r[43:0], $urandom_range(0, 3), 0, tdummy);
        end

        to = 0;
        while ((sb.size() != 0 || busy) && to < 200) begin
            @(negedge clk);
            to++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("frames_rx", frames_rx, frames_tx - aborted);
        chk("aborted", aborted, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
